pitch_stabilizer: RTL and testbench

Downstream stage of the FFT pitch detector. It consumes the raw per-frame peak-bin stream (`pitch_output` of `fft_pitch_detect`) and emits a debounced pitch bin. Spurious single-frame peaks are removed by a 3-tap median filter. A new pitch is reported only after it has held steady within a tolerance for `HOLD` consecutive medians. Low bins are treated as silence.

---
 rtl/pitch_stabilizer.sv | 167 ++++++++++++++++
 tb/tb_pitch_stabilizer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pitch_stabilizer.sv
// Debounces the raw per-frame FFT peak bin: 3-tap median, tolerance-based hold
// counting before a new pitch is reported, and low bins treated as silence.
module pitch_stabilizer #(
  parameter int W       = 10,
  parameter int TOL     = 2,
  parameter int HOLD    = 3,
  parameter int MIN_BIN = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] pitch_input_data,
  input  logic         pitch_input_valid,
  output logic         pitch_input_ready,
  output logic [W-1:0] pitch_output_data,
  output logic         pitch_output_valid,
  input  logic         pitch_output_ready
);

  localparam int RW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam logic [RW-1:0] HOLD_R  = RW'(HOLD);
  localparam logic [W:0]    TOL_D   = (W + 1)'(TOL);
  localparam logic [W-1:0]  MIN_D   = W'(MIN_BIN);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  function automatic logic [W-1:0] med3(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] r;
    if ((a >= b && a <= c) || (a <= b && a >= c)) begin
      r = a;
    end else if ((b >= a && b <= c) || (b <= a && b >= c)) begin
      r = b;
    end else begin
      r = c;
    end
    return r;
  endfunction

  // Extra bit keeps the difference from wrapping.
  function automatic logic [W:0] abs_diff(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [W:0] r;
    if (a >= b) begin
      r = {1'b0, a} - {1'b0, b};
    end else begin
      r = {1'b0, b} - {1'b0, a};
    end
    return r;
  endfunction

  state_t        state_r, state_nx_s;
  logic [1:0]    cnt_r, cnt_nx_s, cnt_inc_s;
  logic [W-1:0]  h1_r, h0_r, h1_nx_s, h0_nx_s;
  logic [W-1:0]  cand_r, cand_nx_s;
  logic [RW-1:0] run_r, run_nx_s;
  logic [W-1:0]  med_s;
  logic          close_s, replaced_s, accept_s, silent_s;
  logic          emit_s;
  logic [W-1:0]  emit_data_s;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;

  assign pitch_input_ready  = reset && (!out_valid_r || pitch_output_ready);
  assign pitch_output_valid = out_valid_r;
  assign pitch_output_data  = out_data_r;

  assign accept_s  = pitch_input_valid && pitch_input_ready;
  assign silent_s  = pitch_input_data < MIN_D;
  assign med_s     = med3(h1_r, h0_r, pitch_input_data);
  assign close_s   = abs_diff(med_s, cand_r) <= TOL_D;
  assign cnt_inc_s = (cnt_r == 2'd3) ? 2'd3 : cnt_r + 2'd1;

  // Next-state, history/candidate update and emit decision for one accepted sample.
  always_comb begin
    state_nx_s  = state_r;
    cnt_nx_s    = cnt_r;
    h1_nx_s     = h1_r;
    h0_nx_s     = h0_r;
    cand_nx_s   = cand_r;
    run_nx_s    = run_r;
    replaced_s  = 1'b0;
    emit_s      = 1'b0;
    emit_data_s = '0;
    if (accept_s) begin
      if (silent_s) begin
        state_nx_s = FILL;
        cnt_nx_s   = 2'd0;
        h1_nx_s    = '0;
        h0_nx_s    = '0;
        cand_nx_s  = '0;
        run_nx_s   = '0;
        if (state_r == LOCKED) begin
          emit_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end else begin
        h1_nx_s  = h0_r;
        h0_nx_s  = pitch_input_data;
        cnt_nx_s = cnt_inc_s;
        if (cnt_inc_s == 2'd3) begin
          // The first median out of FILL always starts a fresh candidate.
          if (state_r != FILL && close_s) begin
            run_nx_s = (run_r == HOLD_R) ? run_r : run_r + RW'(1);
          end else begin
            cand_nx_s  = med_s;
            run_nx_s   = RW'(1);
            replaced_s = 1'b1;
          end
          if (run_nx_s == HOLD_R && (run_r != HOLD_R || replaced_s)) begin
            emit_s      = 1'b1;
            emit_data_s = cand_nx_s;
            state_nx_s  = LOCKED;
          end else if (state_r == FILL) begin
            state_nx_s = TRACK;
          end else begin
            state_nx_s = state_r;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
    end else begin
      state_nx_s = state_r;
    end
  end

  // Tracking state registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= FILL;
      cnt_r   <= 2'd0;
      h1_r    <= '0;
      h0_r    <= '0;
      cand_r  <= '0;
      run_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      h1_r    <= h1_nx_s;
      h0_r    <= h0_nx_s;
      cand_r  <= cand_nx_s;
      run_r   <= run_nx_s;
    end
  end

  // Output register: load on emit, hold under backpressure, clear on handshake.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (emit_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= emit_data_s;
    end else if (pitch_output_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_pitch_stabilizer.sv
// Bench for pitch_stabilizer: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a queue-based behavioural model.
module tb_pitch_stabilizer;

  localparam int W       = 10;
  localparam int TOL     = 2;
  localparam int HOLD    = 3;
  localparam int MIN_BIN = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] pin_data = '0;
  logic         pin_valid = 1'b0;
  logic         pin_ready;
  logic [W-1:0] pout_data;
  logic         pout_valid;
  logic         pout_ready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int hist[$];
  int cand = 0;
  int run  = 0;
  bit locked = 1'b0;
  bit m_valid = 1'b0;
  int m_data  = 0;

  always #5 clk = ~clk;

  pitch_stabilizer #(.W(W), .TOL(TOL), .HOLD(HOLD), .MIN_BIN(MIN_BIN)) dut (
    .clk(clk),
    .reset(rst),
    .pitch_input_data(pin_data),
    .pitch_input_valid(pin_valid),
    .pitch_input_ready(pin_ready),
    .pitch_output_data(pout_data),
    .pitch_output_valid(pout_valid),
    .pitch_output_ready(pout_ready)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one accepted sample to the model; returns whether an output is produced.
  task automatic model_sample(input int x, output bit em, output int ev);
    int s[$];
    int m, old, d;
    bit repl;
    em = 1'b0;
    ev = 0;
    if (x < MIN_BIN) begin
      if (locked) begin
        em = 1'b1;
        ev = 0;
      end
      hist.delete();
      cand = 0;
      run = 0;
      locked = 1'b0;
    end else begin
      hist.push_back(x);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3) begin
        s = hist;
        s.sort();
        m = s[1];
        d = (m > cand) ? m - cand : cand - m;
        repl = (run == 0) || (d > TOL);
        old = run;
        if (repl) begin
          cand = m;
          run = 1;
        end else begin
          run = (run + 1 > HOLD) ? HOLD : run + 1;
        end
        if (run == HOLD && (old != HOLD || repl)) begin
          em = 1'b1;
          ev = cand;
          locked = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input int d, input bit v, input bit r, input bit rs);
    bit acc, em;
    int ev;
    pin_data = d[W-1:0];
    pin_valid = v;
    pout_ready = r;
    rst = rs;
    #1;
    chk("in_ready", int'(pin_ready), int'(rs && (!m_valid || r)));
    @(posedge clk);
    acc = v && rs && (!m_valid || r);
    em = 1'b0;
    ev = 0;
    if (!rs) begin
      hist.delete();
      cand = 0;
      run = 0;
      locked = 1'b0;
      m_valid = 1'b0;
      m_data = 0;
    end else begin
      if (acc) model_sample(d, em, ev);
      if (em) begin
        m_valid = 1'b1;
        m_data = ev;
      end else if (r) begin
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("out_valid", int'(pout_valid), int'(m_valid));
    if (m_valid) chk("out_data", int'(pout_data), m_data);
  endtask

  task automatic feed(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b1, 1'b1, 1'b1);
  endtask

  int pool[8] = '{0, 1, 40, 41, 42, 45, 80, 200};

  initial begin
    @(negedge clk);
    step(0, 1'b1, 1'b1, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0);
    chk("reset_valid", int'(pout_valid), 0);
    chk("reset_data", int'(pout_data), 0);

    // lock
    feed(40, 4);
    chk("lock_early", int'(pout_valid), 0);
    feed(40, 1);
    chk("lock_valid", int'(pout_valid), 1);
    chk("lock_data", int'(pout_data), 40);
    feed(40, 10);
    chk("lock_quiet", int'(pout_valid), 0);

    // outlier rejection
    feed(40, 1); feed(200, 1); feed(40, 1); feed(41, 1); feed(39, 1);
    chk("outlier_quiet", int'(pout_valid), 0);
    feed(40, 2);

    // pitch change
    feed(80, 3);
    chk("change_early", int'(pout_valid), 0);
    feed(80, 1);
    chk("change_data", int'(pout_data), 80);

    // silence
    feed(1, 1);
    chk("silence_valid", int'(pout_valid), 1);
    chk("silence_data", int'(pout_data), 0);
    feed(1, 3);
    chk("silence_quiet", int'(pout_valid), 0);
    feed(50, 5);
    chk("resume_data", int'(pout_data), 50);

    // backpressure
    feed(1, 1);
    step(0, 1'b0, 1'b1, 1'b1);
    feed(40, 5);
    for (int i = 0; i < 20; i++) begin
      step(40, 1'b1, 1'b0, 1'b1);
      chk("bp_in_ready", int'(pin_ready), 0);
      chk("bp_data", int'(pout_data), 40);
    end
    step(40, 1'b1, 1'b1, 1'b1);
    chk("bp_release", int'(pout_valid), 0);

    // reset mid-run
    feed(1, 1);
    step(0, 1'b0, 1'b1, 1'b1);
    feed(60, 4);
    step(60, 1'b1, 1'b1, 1'b0);
    chk("mid_reset_valid", int'(pout_valid), 0);
    feed(60, 4);
    chk("post_reset_quiet", int'(pout_valid), 0);
    feed(60, 1);
    chk("post_reset_data", int'(pout_data), 60);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int d;
      d = pool[$urandom_range(7, 0)] + (($urandom_range(3, 0) == 0) ? $urandom_range(3, 0) : 0);
      step(d, $urandom_range(3, 0) != 0, $urandom_range(9, 0) < 7,
           $urandom_range(199, 0) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
